grayscale_flow_sched: RTL

- Sequences one grayscale job: issues cache-line read requests over a source region and feeds results from the grayscale pipeline back out as write requests to a destination region.
- Sits between the CSR block, which supplies start/base/length, and the CCI-P c0/c1 request path.
- Uses credit-based flow control so that every line in flight can be absorbed by an internal output FIFO while c1 is almost-full. No data is ever dropped.

---
 rtl/grayscale_flow_sched_if.sv | 40 ++++
 rtl/grayscale_flow_sched.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/grayscale_flow_sched_if.sv
// Request/response bundle between the grayscale flow scheduler, the CSR
// block, the grayscale pipeline and the CCI-P c0/c1 request path.
interface grayscale_flow_sched_if #(
    parameter int ADDR_W = 42,
    parameter int DATA_W = 512,
    parameter int LEN_W  = 32
) ();
    logic              start;
    logic [ADDR_W-1:0] src_base;
    logic [ADDR_W-1:0] dst_base;
    logic [LEN_W-1:0]  num_lines;
    logic              busy;
    logic              done;
    logic              rd_req_valid;
    logic [ADDR_W-1:0] rd_req_addr;
    logic              rd_almfull;
    logic              dp_valid;
    logic [DATA_W-1:0] dp_data;
    logic              wr_req_valid;
    logic [ADDR_W-1:0] wr_req_addr;
    logic [DATA_W-1:0] wr_req_data;
    logic              wr_almfull;
    logic              wr_rsp_valid;

    // Scheduler side: issues read/write requests and reports job status
    modport master (
        input  start, src_base, dst_base, num_lines,
        input  rd_almfull, dp_valid, dp_data, wr_almfull, wr_rsp_valid,
        output busy, done, rd_req_valid, rd_req_addr,
        output wr_req_valid, wr_req_addr, wr_req_data
    );

    // Environment side: CSR block, pipeline and CCI-P channels
    modport slave (
        output start, src_base, dst_base, num_lines,
        output rd_almfull, dp_valid, dp_data, wr_almfull, wr_rsp_valid,
        input  busy, done, rd_req_valid, rd_req_addr,
        input  wr_req_valid, wr_req_addr, wr_req_data
    );
endinterface

// File: rtl/grayscale_flow_sched.sv
// Grayscale job sequencer: streams cache-line reads over the source region,
// buffers pipeline results in a credit-sized FIFO and writes them back to the
// destination region in order. Credits guarantee the FIFO can absorb every
// line in flight while the write channel is backpressured.
module grayscale_flow_sched #(
    parameter int ADDR_W  = 42,
    parameter int DATA_W  = 512,
    parameter int CREDITS = 16,
    parameter int LEN_W   = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    grayscale_flow_sched_if.master bus
);
    localparam int PTR_W = $clog2(CREDITS);
    localparam logic [PTR_W:0]   CREDIT_LIMIT = (PTR_W+1)'(CREDITS);
    localparam logic [PTR_W:0]   PTR_ONE      = (PTR_W+1)'(1);
    localparam logic [LEN_W-1:0] CNT_ONE      = LEN_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, ack_cnt_q, ack_cnt_d;
    logic [PTR_W:0]    inflight_q, inflight_d;
    logic [PTR_W:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DATA_W-1:0] mem [CREDITS];

    logic              busy_q, busy_d, done_q, done_d;
    logic              rd_req_valid_q, rd_req_valid_d;
    logic [ADDR_W-1:0] rd_req_addr_q, rd_req_addr_d;
    logic              wr_req_valid_q, wr_req_valid_d;
    logic [ADDR_W-1:0] wr_req_addr_q, wr_req_addr_d;
    logic [DATA_W-1:0] wr_req_data_q, wr_req_data_d;

    logic active, fifo_empty, fifo_full, rd_issue, push, pop;

    assign active     = (state_q == RUN) || (state_q == DRAIN);
    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                        (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
    assign rd_issue   = (state_q == RUN) && (rd_cnt_q < len_q) &&
                        !bus.rd_almfull && (inflight_q < CREDIT_LIMIT);
    assign push       = active && bus.dp_valid;
    assign pop        = active && !fifo_empty && !bus.wr_almfull;

    // Job sequencing, counters, credit tracking and FIFO pointer advance
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        len_d      = len_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        ack_cnt_d  = ack_cnt_q;
        inflight_d = inflight_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    src_d      = bus.src_base;
                    dst_d      = bus.dst_base;
                    len_d      = bus.num_lines;
                    rd_cnt_d   = '0;
                    wr_cnt_d   = '0;
                    ack_cnt_d  = '0;
                    inflight_d = '0;
                    wptr_d     = '0;
                    rptr_d     = '0;
                    state_d    = (bus.num_lines != '0) ? RUN : DONE;
                end
            end
            RUN, DRAIN: begin
                if (rd_issue)         rd_cnt_d  = rd_cnt_q + CNT_ONE;
                if (pop)              wr_cnt_d  = wr_cnt_q + CNT_ONE;
                if (bus.wr_rsp_valid) ack_cnt_d = ack_cnt_q + CNT_ONE;
                if (push)             wptr_d    = wptr_q + PTR_ONE;
                if (pop)              rptr_d    = rptr_q + PTR_ONE;
                if (rd_issue && !pop)      inflight_d = inflight_q + PTR_ONE;
                else if (!rd_issue && pop) inflight_d = inflight_q - PTR_ONE;
                if ((rd_cnt_q == len_q) && (wr_cnt_q == len_q) && (ack_cnt_q == len_q))
                    state_d = DONE;
                else if ((state_q == RUN) && (rd_cnt_q == len_q))
                    state_d = DRAIN;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered request and status outputs
    always_comb begin
        rd_req_valid_d = rd_issue;
        rd_req_addr_d  = rd_req_addr_q;
        wr_req_valid_d = pop;
        wr_req_addr_d  = wr_req_addr_q;
        wr_req_data_d  = wr_req_data_q;
        busy_d         = active;
        done_d         = (state_q == DONE);
        if (rd_issue) rd_req_addr_d = src_q + ADDR_W'(rd_cnt_q);
        if (pop) begin
            wr_req_addr_d = dst_q + ADDR_W'(wr_cnt_q);
            wr_req_data_d = mem[rptr_q[PTR_W-1:0]];
        end
    end

    // State and output registers; reset aborts any job in progress
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            src_q          <= '0;
            dst_q          <= '0;
            len_q          <= '0;
            rd_cnt_q       <= '0;
            wr_cnt_q       <= '0;
            ack_cnt_q      <= '0;
            inflight_q     <= '0;
            wptr_q         <= '0;
            rptr_q         <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            rd_req_valid_q <= 1'b0;
            rd_req_addr_q  <= '0;
            wr_req_valid_q <= 1'b0;
            wr_req_addr_q  <= '0;
            wr_req_data_q  <= '0;
        end else begin
            state_q        <= state_d;
            src_q          <= src_d;
            dst_q          <= dst_d;
            len_q          <= len_d;
            rd_cnt_q       <= rd_cnt_d;
            wr_cnt_q       <= wr_cnt_d;
            ack_cnt_q      <= ack_cnt_d;
            inflight_q     <= inflight_d;
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            rd_req_valid_q <= rd_req_valid_d;
            rd_req_addr_q  <= rd_req_addr_d;
            wr_req_valid_q <= wr_req_valid_d;
            wr_req_addr_q  <= wr_req_addr_d;
            wr_req_data_q  <= wr_req_data_d;
        end
    end

    // Output FIFO storage; contents need no reset since pointers gate reads
    always_ff @(posedge clk) begin
        if (push) mem[wptr_q[PTR_W-1:0]] <= bus.dp_data;
    end

    push_into_full_a: assert property (@(posedge clk) disable iff (!reset) !(push && fifo_full));
    pop_from_empty_a: assert property (@(posedge clk) disable iff (!reset) !(pop && fifo_empty));

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.rd_req_valid = rd_req_valid_q;
    assign bus.rd_req_addr  = rd_req_addr_q;
    assign bus.wr_req_valid = wr_req_valid_q;
    assign bus.wr_req_addr  = wr_req_addr_q;
    assign bus.wr_req_data  = wr_req_data_q;
endmodule
